// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
//   cmp_state_t       : controller state encoding (IDLE, SHIFT, DONE)
//   CMP_DEFAULT_WIDTH : default operand width
package serial_cmp_pkg;

    localparam int unsigned CMP_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/bit_compare_cell.sv
// One slice of the equal/greater comparator cascade (MSB-first recurrence).
// Ports:
//   a_i, b_i : current operand bits
//   e_in     : higher-order bits equal so far
//   g_in     : B already decided greater than A
//   e_out    : equality carried past this bit
//   g_out    : B-greater carried past this bit
module bit_compare_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic e_in,
    input  logic g_in,
    output logic e_out,
    output logic g_out
);

    assign e_out = e_in & ~(a_i ^ b_i);
    assign g_out = g_in | (~a_i & b_i & e_in);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: accepts A/B over a valid/ready handshake,
// walks one bit per clock MSB first through a single bit_compare_cell, then
// presents eq / b_gt_a / a_gt_b over a second valid/ready handshake.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN -- leave SHIFT at the first
// differing bit instead of always walking all WIDTH bits.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid, in_ready   : operand handshake
//   a, b                 : operands (WIDTH bits)
//   out_valid, out_ready : result handshake
//   eq, b_gt_a, a_gt_b   : result flags, zero while out_valid is low
//   busy                 : high in SHIFT and DONE
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             b_gt_a,
    output logic             a_gt_b,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    cmp_state_t       state;
    cmp_state_t       state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             e;
    logic             g;
    logic [CNT_W-1:0] cnt;
    logic             e_next;
    logic             g_next;
    logic             load;
    logic             step;

    // Single reused slice, fed by the shift-register MSBs.
    bit_compare_cell u_cell (
        .a_i   (a_sh[WIDTH-1]),
        .b_i   (b_sh[WIDTH-1]),
        .e_in  (e),
        .g_in  (g),
        .e_out (e_next),
        .g_out (g_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                // The result is settled at the first differing bit.
                if (!e_next) begin
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shift registers, cascade flops and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            e    <= 1'b1;
            g    <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            e    <= 1'b1;
            g    <= 1'b0;
            cnt  <= CNT_W'(WIDTH);
        end else if (step) begin
            a_sh <= {a_sh[WIDTH-2:0], 1'b0};
            b_sh <= {b_sh[WIDTH-2:0], 1'b0};
            e    <= e_next;
            g    <= g_next;
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Outputs decode registered state only; flags are gated by out_valid.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign eq        = out_valid & e;
    assign b_gt_a    = out_valid & g;
    assign a_gt_b    = out_valid & ~e & ~g;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and sweep bench for serial_magnitude_comparator at WIDTH=8.
// Latency expectations follow SERIAL_CMP_EARLY_EXIT_EN when defined.
module tb_serial_magnitude_comparator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic       eq;
    logic       b_gt_a;
    logic       a_gt_b;
    logic       busy;

    int errors = 0;
    int checks = 0;

    serial_magnitude_comparator #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .b_gt_a    (b_gt_a),
        .a_gt_b    (a_gt_b),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected latency from acceptance to out_valid for a pair.
    function automatic int exp_latency(input logic [7:0] av, input logic [7:0] bv);
        int lat;
        lat = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int i = 7; i >= 0; i--) begin
            if (av[i] != bv[i]) begin
                lat = 8 - i;
                break;
            end
        end
`endif
        return lat;
    endfunction

    // Present operands, wait for acceptance, then count cycles to out_valid.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        n        = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, eq, b_gt_a, a_gt_b, busy, in_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=000001",
                     {out_valid, eq, b_gt_a, a_gt_b, busy, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_idle got=%b want=001", {out_valid, busy, in_ready});
        end
    endtask

    // Run one pair with out_ready high and check flags, latency and return to IDLE.
    task automatic test_pair(input string name, input logic [7:0] av, input logic [7:0] bv,
                             input logic [2:0] flags, input int lat_exp);
        int lat;
        out_ready = 1'b1;
        send(av, bv, lat);
        checks++;
        if (lat !== lat_exp) begin
            errors++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, lat_exp);
        end
        checks++;
        if ({eq, b_gt_a, a_gt_b} !== flags) begin
            errors++;
            $display("FAIL %s_flags got=%b want=%b", name, {eq, b_gt_a, a_gt_b}, flags);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_status got busy=%b in_ready=%b want busy=1 in_ready=0",
                     name, busy, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, eq, b_gt_a, a_gt_b, busy, in_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL %s_release got=%b want=000001", name,
                     {out_valid, eq, b_gt_a, a_gt_b, busy, in_ready});
        end
    endtask

    task automatic test_equal();
        test_pair("equal", 8'h5A, 8'h5A, 3'b100, 8);
    endtask

    task automatic test_b_greater();
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        test_pair("b_greater", 8'h10, 8'h80, 3'b010, 1);
`else
        test_pair("b_greater", 8'h10, 8'h80, 3'b010, 8);
`endif
    endtask

    task automatic test_a_greater();
        test_pair("a_greater", 8'hFF, 8'hFE, 3'b001, 8);
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(8'h42, 8'h43, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL bp_latency got=%0d want=8", lat);
        end
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, eq, b_gt_a, a_gt_b, in_ready} !== 5'b10100) begin
                errors++;
                $display("FAIL bp_hold[%0d] got=%b want=10100", i,
                         {out_valid, eq, b_gt_a, a_gt_b, in_ready});
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL bp_release got=%b want=001", {out_valid, busy, in_ready});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_reaccept got=%b want=10", {busy, in_ready});
        end
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        if (!out_valid) lat = 99;
        checks++;
        if (lat !== exp_latency(8'hFF, 8'h00) || {eq, b_gt_a, a_gt_b} !== 3'b001) begin
            errors++;
            $display("FAIL bp_second got lat=%0d flags=%b want lat=%0d flags=001",
                     lat, {eq, b_gt_a, a_gt_b}, exp_latency(8'hFF, 8'h00));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_shift();
        int n;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'hAA;
        n        = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, eq, b_gt_a, a_gt_b, busy, in_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL mid_reset got=%b want=000001",
                     {out_valid, eq, b_gt_a, a_gt_b, busy, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_pair("after_reset", 8'h01, 8'h02, 3'b010, exp_latency(8'h01, 8'h02));
    endtask

    task automatic test_random_sweep();
        logic [7:0] av;
        logic [7:0] bv;
        logic [2:0] want;
        int         lat;
        int         stall;
        for (int k = 0; k < 1000; k++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            if (k % 7 == 0) bv = av;
            out_ready = 1'b0;
            send(av, bv, lat);
            want = {av == bv, bv > av, av > bv};
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (lat !== exp_latency(av, bv) || {eq, b_gt_a, a_gt_b} !== want
                || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep[%0d] a=%h b=%h got lat=%0d flags=%b want lat=%0d flags=%b",
                         k, av, bv, lat, {eq, b_gt_a, a_gt_b}, exp_latency(av, bv), want);
            end
            checks++;
            if ((32'(eq) + 32'(b_gt_a) + 32'(a_gt_b)) !== 1) begin
                errors++;
                $display("FAIL sweep_onehot[%0d] got=%b want exactly one set", k,
                         {eq, b_gt_a, a_gt_b});
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL sweep_release[%0d] got=%b want=01", k, {out_valid, in_ready});
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_b_greater();
        test_a_greater();
        test_backpressure();
        test_reset_mid_shift();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
